// File: rtl/mem_io_responder_pkg.sv
// Shared types and constants for the CPU memory-bus responder.
// I/O space sits at 0x30000; UART data at offset 0, clock counter bytes at offsets 4..7.
package mem_io_responder_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [31:0] IoBase    = 32'h0003_0000;
    localparam logic [2:0]  IoUartOff = 3'd0;
    localparam logic [2:0]  IoClkOff  = 3'd4;

    typedef enum logic [1:0] {RegNone, RegUart, RegClk} io_reg_e;

    function automatic io_reg_e decode_io_reg(logic [2:0] off);
        if (off == IoUartOff) begin
            return RegUart;
        end else if (off[2] == IoClkOff[2]) begin
            return RegClk;
        end
        return RegNone;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte-wide memory bus: address, direction, write byte, read byte and TX back-pressure.
interface mem_io_responder_if;

    logic [31:0]                        cpu_a;
    logic                               cpu_wr;
    mem_io_responder_pkg::byte_t        cpu_dout;
    mem_io_responder_pkg::byte_t        cpu_din;
    logic                               io_buffer_full;

    modport master (
        output cpu_a,
        output cpu_wr,
        output cpu_dout,
        input  cpu_din,
        input  io_buffer_full
    );

    modport slave (
        input  cpu_a,
        input  cpu_wr,
        input  cpu_dout,
        output cpu_din,
        output io_buffer_full
    );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; push on full and pop on empty are ignored.
module mem_io_responder_byte_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  byte_t            din_i,
    output byte_t            dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [FIFO_AW:0] free_cnt_o
);

    localparam int unsigned        Depth  = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   PtrOne = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   DepthW = (FIFO_AW + 1)'(Depth);

    logic [FIFO_AW:0] wptr_q, wptr_d;
    logic [FIFO_AW:0] rptr_q, rptr_d;
    byte_t            mem_q [Depth];
    byte_t            mem_d [Depth];
    logic             push_ok, pop_ok;

    assign empty_o    = (wptr_q == rptr_q);
    assign full_o     = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                        (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    assign free_cnt_o = DepthW - (wptr_q - rptr_q);
    assign dout_o     = mem_q[rptr_q[FIFO_AW-1:0]];
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (push_ok) begin
            mem_d[wptr_q[FIFO_AW-1:0]] = din_i;
            wptr_d = wptr_q + PtrOne;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: contents are unreachable while the pointers say empty.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-bus responder: RAM / MMIO decode, one-cycle read return, UART TX/RX FIFOs,
// free-running clock counter with byte snapshot, and sticky program-done.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned RAM_AW      = 17,
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_io_responder_if.slave bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output byte_t             ram_wdata,
    input  byte_t             ram_rdata,
    output logic              tx_valid,
    output byte_t             tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  byte_t             rx_data,
    output logic              rx_ready,
    output logic              program_done,
    output logic              tx_overflow
);

    localparam logic [FIFO_AW:0] MarginW = (FIFO_AW + 1)'(FULL_MARGIN);
    localparam logic [FIFO_AW:0] ZeroW   = '0;

    logic             is_io, rd_cyc;
    logic [2:0]       io_off;
    io_reg_e          io_reg;
    logic             unused_addr;

    logic             tx_push, tx_pop, tx_empty, tx_full, tx_push_eff;
    byte_t            tx_din, tx_dout;
    logic [FIFO_AW:0] tx_free, tx_free_next;
    logic             rx_push, rx_pop, rx_empty, rx_full;
    byte_t            rx_dout;
    logic [FIFO_AW:0] rx_free;

    logic             done_set;
    byte_t            io_byte, din;

    logic             rd_q, rd_d;
    logic             src_ram_q, src_ram_d;
    byte_t            io_byte_q, io_byte_d;
    byte_t            hold_q, hold_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             full_q, full_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      snap_q, snap_d;

    assign is_io       = (bus.cpu_a[17:16] == IoBase[17:16]);
    assign io_off      = bus.cpu_a[2:0];
    assign io_reg      = decode_io_reg(io_off);
    assign rd_cyc      = is_io && !bus.cpu_wr;
    assign unused_addr = ^{bus.cpu_a[31:18], rx_free};

    always_comb begin
        ram_en    = !is_io;
        ram_we    = !is_io && bus.cpu_wr;
        ram_addr  = bus.cpu_a[RAM_AW-1:0];
        ram_wdata = bus.cpu_dout;
    end

    // I/O side effects: TX pushes, RX pops and the done flag.
    always_comb begin
        tx_push  = 1'b0;
        tx_din   = bus.cpu_dout;
        rx_pop   = 1'b0;
        done_set = 1'b0;
        if (is_io && bus.cpu_wr) begin
            unique case (io_reg)
                RegUart: tx_push = (bus.cpu_dout != 8'h00);
                RegClk: begin
                    if (io_off == IoClkOff) begin
                        tx_push  = 1'b1;
                        tx_din   = 8'h00;
                        done_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (rd_cyc && io_reg == RegUart) begin
            rx_pop = !rx_empty;
        end
    end

    // Offset 4 returns the live counter and latches it; 5..7 read the latched copy.
    always_comb begin
        io_byte = 8'h00;
        snap_d  = snap_q;
        if (rd_cyc) begin
            unique case (io_reg)
                RegUart: io_byte = rx_empty ? 8'h00 : rx_dout;
                RegClk: begin
                    unique case (io_off[1:0])
                        2'd1:    io_byte = snap_q[15:8];
                        2'd2:    io_byte = snap_q[23:16];
                        2'd3:    io_byte = snap_q[31:24];
                        default: begin
                            io_byte = cnt_q[7:0];
                            snap_d  = cnt_q;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_pop       = !tx_empty && tx_ready;
        tx_push_eff  = tx_push && !tx_full;
        tx_free_next = tx_free + {ZeroW[FIFO_AW:1], tx_pop} - {ZeroW[FIFO_AW:1], tx_push_eff};
        rx_push      = rx_valid && !rx_full;
    end

    always_comb begin
        din       = rd_q ? (src_ram_q ? ram_rdata : io_byte_q) : hold_q;
        rd_d      = !bus.cpu_wr;
        src_ram_d = !is_io;
        io_byte_d = io_byte;
        hold_d    = din;
        done_d    = done_q || done_set;
        ovf_d     = ovf_q || (tx_push && tx_full);
        full_d    = (tx_free_next <= MarginW);
        cnt_d     = cnt_q + 32'd1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_q      <= 1'b0;
            src_ram_q <= 1'b0;
            io_byte_q <= 8'h00;
            hold_q    <= 8'h00;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            full_q    <= 1'b0;
            cnt_q     <= 32'd0;
            snap_q    <= 32'd0;
        end else begin
            rd_q      <= rd_d;
            src_ram_q <= src_ram_d;
            io_byte_q <= io_byte_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            full_q    <= full_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
        end
    end

    assign bus.cpu_din        = din;
    assign bus.io_buffer_full = full_q;
    assign tx_valid           = !tx_empty;
    assign tx_data            = tx_dout;
    assign rx_ready           = !rx_full;
    assign program_done       = done_q;
    assign tx_overflow        = ovf_q;

    mem_io_responder_byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_tx_fifo (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .push_i     (tx_push),
        .pop_i      (tx_pop),
        .din_i      (tx_din),
        .dout_o     (tx_dout),
        .empty_o    (tx_empty),
        .full_o     (tx_full),
        .free_cnt_o (tx_free)
    );

    mem_io_responder_byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_rx_fifo (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .push_i     (rx_push),
        .pop_i      (rx_pop),
        .din_i      (rx_data),
        .dout_o     (rx_dout),
        .empty_o    (rx_empty),
        .full_o     (rx_full),
        .free_cnt_o (rx_free)
    );

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: bus-op vector table plus TX/RX/counter/reset sequences.
module tb_mem_io_responder;
    import mem_io_responder_pkg::*;

    localparam int unsigned RAM_AW = 17;

    logic              clk = 1'b0;
    logic              rst;
    logic              ram_en, ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata = 8'h00;
    logic              tx_valid, tx_ready;
    logic [7:0]        tx_data;
    logic              rx_valid, rx_ready;
    logic [7:0]        rx_data;
    logic              program_done, tx_overflow;

    int total = 0;
    int bad   = 0;

    mem_io_responder_if bus ();

    mem_io_responder #(
        .RAM_AW      (RAM_AW),
        .FIFO_AW     (4),
        .FULL_MARGIN (2)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .bus          (bus),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .program_done (program_done),
        .tx_overflow  (tx_overflow)
    );

    always #5 clk = ~clk;

    // Synchronous board RAM model.
    logic [7:0] ram_mem [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Reference clock counter and TX stream capture.
    logic [31:0] mdl_cnt = 32'd0;
    logic [7:0]  txq [$];
    always @(posedge clk) begin
        mdl_cnt <= rst ? 32'd0 : mdl_cnt + 32'd1;
        if (!rst && tx_valid && tx_ready) txq.push_back(tx_data);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        logic        en;
        logic        we;
        logic [16:0] addr;
        logic [7:0]  din;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_op(input logic [31:0] a, input logic wr, input logic [7:0] d);
        bus.cpu_a    = a;
        bus.cpu_wr   = wr;
        bus.cpu_dout = d;
    endtask

    task automatic idle();
        bus_op(32'h0003_0002, 1'b0, 8'h00);
    endtask

    function automatic logic [7:0] txq_at(input int k);
        return (k < txq.size()) ? txq[k] : 8'hEE;
    endfunction

    initial begin
        int n;

        vecs[0]  = '{32'h0000_0123, 1'b1, 8'hAB, 1'b1, 1'b1, 17'h00123, 8'h00};
        vecs[1]  = '{32'h0000_0123, 1'b0, 8'h00, 1'b1, 1'b0, 17'h00123, 8'hAB};
        vecs[2]  = '{32'h0001_FFFF, 1'b1, 8'h3C, 1'b1, 1'b1, 17'h1FFFF, 8'hAB};
        vecs[3]  = '{32'h0002_0000, 1'b1, 8'h77, 1'b1, 1'b1, 17'h00000, 8'hAB};
        vecs[4]  = '{32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 1'b0, 17'h1FFFF, 8'h3C};
        vecs[5]  = '{32'h0000_0000, 1'b0, 8'h00, 1'b1, 1'b0, 17'h00000, 8'h77};
        vecs[6]  = '{32'h0003_0000, 1'b1, 8'h41, 1'b0, 1'b0, 17'h10000, 8'h77};
        vecs[7]  = '{32'h0003_0000, 1'b1, 8'h00, 1'b0, 1'b0, 17'h10000, 8'h77};
        vecs[8]  = '{32'h0003_0000, 1'b1, 8'h42, 1'b0, 1'b0, 17'h10000, 8'h77};
        vecs[9]  = '{32'h0003_0002, 1'b0, 8'h00, 1'b0, 1'b0, 17'h10002, 8'h00};
        vecs[10] = '{32'h0003_0001, 1'b1, 8'h99, 1'b0, 1'b0, 17'h10001, 8'h00};
        vecs[11] = '{32'h0000_0123, 1'b0, 8'h00, 1'b1, 1'b0, 17'h00123, 8'hAB};
        vecs[12] = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 17'h10000, 8'h00};
        vecs[13] = '{32'hFFF3_0005, 1'b0, 8'h00, 1'b0, 1'b0, 17'h10005, 8'h00};
        vecs[14] = '{32'h8000_0123, 1'b0, 8'h00, 1'b1, 1'b0, 17'h00123, 8'hAB};

        // Reset
        rst      = 1'b1;
        tx_ready = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_cpu_din", bus.cpu_din, 8'h00);
        chk("rst_io_full", bus.io_buffer_full, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_done", program_done, 1'b0);
        chk("rst_ovf", tx_overflow, 1'b0);
        chk("rst_ram_en_io", ram_en, 1'b0);

        // Bus-op table
        for (int i = 0; i < 15; i++) begin
            bus_op(vecs[i].a, vecs[i].wr, vecs[i].d);
            #1;
            chk($sformatf("vec%0d_ram_en", i), ram_en, vecs[i].en);
            chk($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].we);
            if (vecs[i].en) chk($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].addr);
            if (vecs[i].we) chk($sformatf("vec%0d_ram_wdata", i), ram_wdata, vecs[i].d);
            tick();
            chk($sformatf("vec%0d_cpu_din", i), bus.cpu_din, vecs[i].din);
        end
        idle();
        repeat (3) tick();
        chk("tx_basic_count", txq.size(), 2);
        chk("tx_basic_b0", txq_at(0), 8'h41);
        chk("tx_basic_b1", txq_at(1), 8'h42);

        // TX fill with stalled sink, then overflow and drain
        tx_ready = 1'b0;
        txq.delete();
        for (int k = 1; k <= 17; k++) begin
            bus_op(32'h0003_0000, 1'b1, 8'(k));
            tick();
            chk($sformatf("tx_fill%0d_io_full", k), bus.io_buffer_full, (k >= 14));
            chk($sformatf("tx_fill%0d_ovf", k), tx_overflow, (k >= 17));
        end
        idle();
        tx_ready = 1'b1;
        repeat (20) tick();
        chk("tx_drain_count", txq.size(), 16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("tx_drain_b%0d", k), txq_at(k), 8'(k + 1));
        end
        chk("tx_drain_valid", tx_valid, 1'b0);
        chk("tx_drain_io_full", bus.io_buffer_full, 1'b0);
        chk("tx_drain_ovf_sticky", tx_overflow, 1'b1);

        // RX single byte, then empty read
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        tick();
        rx_valid = 1'b0;
        bus_op(32'h0003_0000, 1'b0, 8'h00);
        tick();
        chk("rx_first", bus.cpu_din, 8'h5A);
        tick();
        chk("rx_empty", bus.cpu_din, 8'h00);

        // RX fill to full, offer one extra, read all back
        idle();
        for (int i = 0; i < 16; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(8'h10 + i);
            tick();
        end
        chk("rx_full_ready", rx_ready, 1'b0);
        rx_data = 8'hEE;
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_op(32'h0003_0000, 1'b0, 8'h00);
            tick();
            chk($sformatf("rx_read%0d", i), bus.cpu_din, 8'(8'h10 + i));
        end
        tick();
        chk("rx_after_drain", bus.cpu_din, 8'h00);
        chk("rx_ready_again", rx_ready, 1'b1);

        // Counter snapshot at 0x1FF
        idle();
        n = 0;
        while (mdl_cnt != 32'h0000_01FF && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL cnt_reach: got %h expected %h", mdl_cnt, 32'h1FF);
        end
        bus_op(32'h0003_0004, 1'b0, 8'h00);
        tick();
        chk("clk_b0", bus.cpu_din, 8'hFF);
        bus_op(32'h0003_0005, 1'b0, 8'h00);
        tick();
        chk("clk_b1", bus.cpu_din, 8'h01);
        bus_op(32'h0003_0006, 1'b0, 8'h00);
        tick();
        chk("clk_b2", bus.cpu_din, 8'h00);
        bus_op(32'h0003_0007, 1'b0, 8'h00);
        tick();
        chk("clk_b3", bus.cpu_din, 8'h00);
        idle();
        repeat (3) tick();
        bus_op(32'h0003_0005, 1'b0, 8'h00);
        tick();
        chk("clk_b1_held", bus.cpu_din, 8'h01);

        // Program done, terminator, reset mid-drain
        tx_ready = 1'b0;
        txq.delete();
        bus_op(32'h0003_0000, 1'b1, 8'h55);
        tick();
        bus_op(32'h0003_0004, 1'b1, 8'h00);
        tick();
        chk("done_set", program_done, 1'b1);
        bus_op(32'h0003_0000, 1'b1, 8'h66);
        tick();
        idle();
        tx_ready = 1'b1;
        tick();
        tick();
        chk("done_tx_count", txq.size(), 2);
        chk("done_tx_b0", txq_at(0), 8'h55);
        chk("done_tx_term", txq_at(1), 8'h00);
        chk("done_tx_pending", tx_valid, 1'b1);
        chk("done_ovf_before_rst", tx_overflow, 1'b1);
        bus_op(32'h0000_0123, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("mid_rst_cpu_din", bus.cpu_din, 8'h00);
        chk("mid_rst_done", program_done, 1'b0);
        chk("mid_rst_tx_valid", tx_valid, 1'b0);
        chk("mid_rst_ovf", tx_overflow, 1'b0);
        chk("mid_rst_io_full", bus.io_buffer_full, 1'b0);
        chk("mid_rst_rx_ready", rx_ready, 1'b1);
        repeat (3) tick();
        chk("mid_rst_no_tx", txq.size(), 2);
        bus_op(32'h0000_0123, 1'b0, 8'h00);
        tick();
        chk("post_rst_ram_read", bus.cpu_din, 8'hAB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

System-side responder for the CPU's byte-wide memory bus (mem_a / mem_dout / mem_din / mem_wr / io_buffer_full). Decodes each bus cycle as RAM or memory-mapped I/O, drives a synchronous external RAM, returns read data exactly one cycle later and takes writes in one cycle. It sits between the CPU top and the board RAM/UART: it buffers UART TX/RX bytes, provides the free-running clock counter at 0x30004 and raises program-done.

## Interface
- RAM_AW, 17: RAM byte-address width (128 KB).
- FIFO_AW, 4: log2 depth of the TX and RX byte FIFOs (16 entries each).
- FULL_MARGIN, 2: io_buffer_full asserts when TX free entries ≤ this value.

- clk_in  in  1  system clock.
- rst_in  in  1  one clock; reset is synchronous and active-high.
- cpu_a  in  32  bus address from CPU (mem_a); only [17:0] decoded.
- cpu_wr  in  1  1 = write, 0 = read (mem_wr).
- cpu_dout  in  8  write byte from CPU (mem_dout).
- cpu_din  out  8  read byte to CPU (mem_din).
- io_buffer_full  out  1  TX FIFO near full; CPU must hold I/O writes.
- ram_en / ram_we  out  1 / 1  RAM access strobe / write enable.
- ram_addr  out  RAM_AW  RAM byte address.
- ram_wdata  out  8  RAM write byte.
- ram_rdata  in  8  RAM read byte, valid the cycle after ram_en & !ram_we.
- tx_valid / tx_data / tx_ready  out / out / in  1 / 8 / 1  UART TX stream (ready/valid).
- rx_valid / rx_data / rx_ready  in / in / out  1 / 8 / 1  UART RX stream (ready/valid).
- program_done  out  1  sticky; set by write to 0x30004.
- tx_overflow  out  1  sticky; a TX push was dropped because the FIFO was full.

## Operation
- Every cycle is a bus cycle; no idle encoding. I/O space: cpu_a[17:16]==2'b11; all else is RAM (address cpu_a[RAM_AW-1:0]).
- RAM cycle: ram_en=1, ram_we=cpu_wr, ram_addr/ram_wdata driven combinationally from the bus.
- I/O cycle: ram_en=0. Register offset = cpu_a[2:0].
  - Read 0x30000: pop RX FIFO; return popped byte; return 0x00 if empty (no pop).
  - Read 0x30004–0x30007: return byte cpu_a[1:0] (little-endian) of the counter snapshot. Reading offset 4 loads snapshot ← live counter and returns byte 0 of the live value; offsets 5–7 read the held snapshot.
  - Write 0x30000: push cpu_dout into TX FIFO if non-zero; 0x00 ignored.
  - Write 0x30004: set program_done; push 0x00 into TX as terminator.
  - Other I/O offsets: reads return 0x00, writes ignored.
- Read return: a 1-bit source-select plus registered I/O byte is captured at the cycle; next cycle cpu_din = ram_rdata (RAM) or the registered I/O byte. After a write cycle cpu_din holds the previous value.
- TX push while full: dropped, tx_overflow←1. RX: rx_ready = !rx_full; byte accepted on rx_valid & rx_ready.
- TX drain: tx_valid = !tx_empty, tx_data = FIFO head; pop on tx_valid & tx_ready.
- Clock counter: 32-bit, +1 every cycle, wraps 0xFFFFFFFF→0.

## Timing
- Reset values: cpu_din 0x00, io_buffer_full 0, ram_en 0 only as decoded (combinational), tx_valid 0, rx_ready 1, program_done 0, tx_overflow 0, counter 0, snapshot 0, both FIFOs empty.
- Read latency exactly 1 cycle for RAM and I/O; writes complete in the issuing cycle.
- io_buffer_full registered: next-cycle value = (TX free entries after this cycle's push/pop) ≤ FULL_MARGIN.
- Simultaneous push and pop on a FIFO: count unchanged, both take effect; pop on empty and push on full never corrupt pointers. Pointers wrap modulo 2^FIFO_AW with an extra wrap bit for full/empty.
- Reset mid-operation: FIFO contents discarded, pending read return discarded (cpu_din 0x00 next cycle), flags cleared.

## Structure
- Shared `define constants in utils.v: IO_BASE 0x30000, IO_UART_OFF 0, IO_CLK_OFF 4, BYTE_TP [7:0].
- One sub-module: byte_fifo (parameter FIFO_AW; push/pop/din/dout/empty/full/free_cnt), instantiated twice (TX, RX).

## Test plan
- RAM write 0x00123←0xAB, then read 0x00123 → ram_we pulse, cpu_din=0xAB one cycle after read.
- Writes 0x41,0x00,0x42 to 0x30000 with tx_ready=1 → TX stream emits 0x41,0x42 only.
- tx_ready=0, 15 pushes (depth 16) → io_buffer_full=1 after free ≤2; 17th push → dropped, tx_overflow=1.
- RX supplies 0x5A; read 0x30000 twice → 0x5A then 0x00.
- At counter 0x000001FF read 0x30004..0x30007 on consecutive cycles → bytes 0xFF,0x01,0x00,0x00 (snapshot held).
- Write 0x30004 then rst_in pulse mid-drain → program_done 1 then 0, TX empty, cpu_din 0x00.
